// File: rtl/vend_pkg.sv
// Coin codes shared by the coin acceptor front end and the vending controller.
package vend_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_1    = 2'b01;
  localparam coin_t COIN_2    = 2'b10;

  function automatic coin_t coin_code(input logic is_two);
    return is_two ? COIN_2 : COIN_1;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin detector: 2-flop synchronizer, debounce filter and registered
// rising-edge event on the filtered level.
module coin_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic det,
  output logic evt
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          clean_q, clean_d;
  logic          clean_dly_q;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      // The level flips on the cycle the count would hit DEB_CYCLES.
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    evt_d = clean_q & ~clean_dly_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      clean_q     <= 1'b0;
      clean_dly_q <= 1'b0;
      cnt_q       <= '0;
      evt_q       <= 1'b0;
    end else begin
      sync1_q     <= det;
      sync2_q     <= sync1_q;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      cnt_q       <= cnt_d;
      evt_q       <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounced detectors feed a small coin FIFO that is
// drained one code per coin_vld/coin_rdy handshake.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        det1,
  input  logic                        det2,
  input  logic                        coin_rdy,
  output logic [1:0]                  coin,
  output logic                        coin_vld,
  output logic                        reject,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic evt1, evt2;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
    .clk (clk),
    .rst (rst),
    .det (det1),
    .evt (evt1)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb2 (
    .clk (clk),
    .rst (rst),
    .det (det2),
    .evt (evt2)
  );

  coin_t         mem_q [FIFO_DEPTH];
  coin_t         mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          reject_q, reject_d;
  logic          full, pop, push, one_evt;

  always_comb begin
    full     = (cnt_q == (PW + 1)'(FIFO_DEPTH));
    pop      = (cnt_q != '0) & coin_rdy;
    one_evt  = evt1 ^ evt2;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    push     = one_evt & (~full | pop);
    reject_d = (evt1 & evt2) | (one_evt & full & ~pop);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = coin_code(evt2);
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
    end
  end

  // Queue storage holds data only; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign coin_vld = (cnt_q != '0);
  assign coin     = coin_vld ? mem_q[rd_ptr_q] : COIN_NONE;
  assign fifo_cnt = cnt_q;
  assign reject   = reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor at DEB_CYCLES=4, FIFO_DEPTH=4.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst, det1, det2, coin_rdy;
  logic [1:0] coin;
  logic       coin_vld, reject;
  logic [2:0] fifo_cnt;

  int errors = 0;
  int checks = 0;
  int rej_n  = 0;
  int pop_n  = 0;
  int p0     = 0;
  logic [1:0] last_pop = 2'b00;

  coin_acceptor #(.DEB_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .det1     (det1),
    .det2     (det2),
    .coin_rdy (coin_rdy),
    .coin     (coin),
    .coin_vld (coin_vld),
    .reject   (reject),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Count reject cycles and completed handshakes mid-cycle.
  always @(negedge clk) begin
    if (reject) rej_n++;
    if (coin_vld && coin_rdy) begin
      pop_n++;
      last_pop = coin;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic insert(input bit two);
    if (two) det2 = 1'b1;
    else     det1 = 1'b1;
    tick(6);
    det1 = 1'b0;
    det2 = 1'b0;
    tick(14);
  endtask

  initial begin
    rst = 1'b0; det1 = 1'b0; det2 = 1'b0; coin_rdy = 1'b0;
    tick(3);
    check("rst_coin", coin, 2'b00);
    check("rst_vld", coin_vld, 1'b0);
    check("rst_reject", reject, 1'b0);
    check("rst_cnt", fifo_cnt, 3'd0);
    rst = 1'b1;
    tick(2);

    // Single coin with consumer ready
    coin_rdy = 1'b1;
    det1 = 1'b1;
    tick(7);
    check("t1_early_vld", coin_vld, 1'b0);
    tick();
    check("t1_vld", coin_vld, 1'b1);
    check("t1_coin", coin, 2'b01);
    check("t1_cnt", fifo_cnt, 3'd1);
    tick();
    check("t1_vld_drop", coin_vld, 1'b0);
    check("t1_cnt_zero", fifo_cnt, 3'd0);
    tick();
    det1 = 1'b0;
    tick(15);
    check("t1_pops", pop_n, 1);
    check("t1_rejects", rej_n, 0);

    // Glitch shorter than the debounce interval, then exactly long enough
    det2 = 1'b1;
    tick(3);
    det2 = 1'b0;
    tick(20);
    check("glitch3_pops", pop_n, 1);
    check("glitch3_rejects", rej_n, 0);
    det2 = 1'b1;
    tick(4);
    det2 = 1'b0;
    tick(20);
    check("glitch4_pops", pop_n, 2);
    check("glitch4_code", last_pop, 2'b10);

    // Jam: both detectors together
    det1 = 1'b1; det2 = 1'b1;
    tick(8);
    det1 = 1'b0; det2 = 1'b0;
    tick(20);
    check("jam_rejects", rej_n, 1);
    check("jam_pops", pop_n, 2);
    check("jam_cnt", fifo_cnt, 3'd0);

    // Fill the queue, overflow it, then drain back to back
    coin_rdy = 1'b0;
    insert(0); insert(1); insert(0); insert(1);
    check("full_cnt", fifo_cnt, 3'd4);
    check("full_no_reject", rej_n, 1);
    insert(0);
    check("overflow_reject", rej_n, 2);
    check("overflow_cnt", fifo_cnt, 3'd4);
    check("drain_head0", coin, 2'b01);
    coin_rdy = 1'b1;
    tick();
    check("drain_head1", coin, 2'b10);
    check("drain_cnt1", fifo_cnt, 3'd3);
    tick();
    check("drain_head2", coin, 2'b01);
    tick();
    check("drain_head3", coin, 2'b10);
    tick();
    check("drain_empty", coin_vld, 1'b0);
    check("drain_coin_none", coin, 2'b00);
    check("drain_pops", pop_n, 6);
    coin_rdy = 1'b0;

    // Push and pop on the same edge while full
    insert(0); insert(1); insert(1); insert(0);
    check("pp_full", fifo_cnt, 3'd4);
    det2 = 1'b1;
    tick(7);
    coin_rdy = 1'b1;
    tick();
    check("pp_cnt", fifo_cnt, 3'd4);
    check("pp_head1", coin, 2'b10);
    tick();
    check("pp_cnt3", fifo_cnt, 3'd3);
    check("pp_head2", coin, 2'b10);
    tick();
    check("pp_head3", coin, 2'b01);
    tick();
    check("pp_head_new", coin, 2'b10);
    check("pp_cnt1", fifo_cnt, 3'd1);
    tick();
    check("pp_empty", coin_vld, 1'b0);
    det2 = 1'b0;
    coin_rdy = 1'b0;
    tick(20);
    check("pp_no_reject", rej_n, 2);

    // Asynchronous reset mid-stream with det1 held through release
    insert(0); insert(1); insert(0);
    check("ar_cnt3", fifo_cnt, 3'd3);
    det1 = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("ar_coin", coin, 2'b00);
    check("ar_vld", coin_vld, 1'b0);
    check("ar_cnt", fifo_cnt, 3'd0);
    check("ar_reject", reject, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    p0 = pop_n;
    coin_rdy = 1'b1;
    tick(7);
    check("ar_early_vld", coin_vld, 1'b0);
    tick();
    check("ar_vld", coin_vld, 1'b1);
    check("ar_coin1", coin, 2'b01);
    tick(2);
    det1 = 1'b0;
    tick(20);
    check("ar_one_pop", pop_n, p0 + 1);
    check("ar_cnt_end", fifo_cnt, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
